simon_seq_ctrl: RTL and testbench
=================================

// Module: simon_seq_ctrl
// PURPOSE
//  - Game sequencer for the 4-symbol memory game; samples the free-running 0..3 random source.
//  - Grows a stored symbol sequence by one per round and plays it to the LED driver.
//  - Checks player button presses against the stored sequence; flags win or game-over.
//  - Sits between the random generator and the button/LED glue logic.
// PARAMETERS
//  MAX_LEN         16   maximum sequence length (rounds to win); >=1
//  SHOW_CYCLES      4   clk cycles each symbol is shown (led_valid high); >=1
//  GAP_CYCLES       2   clk cycles of dark gap after each shown symbol; >=1
//  TIMEOUT_CYCLES   8   idle INPUT cycles before loss; used only with SIMON_TIMEOUT_EN
//  LEN_W  $clog2(MAX_LEN+1)   derived width of level
// PORTS
//  clk        in   1      clock
//  reset      in   1      asynchronous, active-high reset
//  start      in   1      pulse; begins new game from IDLE, WIN or LOSE
//  rand_in    in   2      random symbol 0..3, sampled only in APPEND
//  btn_valid  in   1      one-cycle pulse per player press
//  btn_val    in   2      pressed symbol, qualified by btn_valid
//  led_valid  out  1      symbol being shown
//  led_val    out  2      shown symbol; 0 when led_valid=0
//  level      out  LEN_W  current sequence length
//  busy       out  1      high in APPEND/SHOW_ON/SHOW_GAP/INPUT
//  game_over  out  1      high in LOSE
//  win        out  1      high in WIN
// BEHAVIOUR
//  - Reset: state=IDLE; all outputs 0; len, idx, timer = 0; sequence storage need not be cleared.
//  - Outputs are Moore, decoded from registered state/idx/len.
//  - IDLE: start -> APPEND with len=0. All other inputs are ignored.
//  - APPEND (1 cycle): seq[len]<=rand_in; len<=len+1; idx<=0.
//    -> SHOW_ON. level shows the new length from SHOW_ON onward.
//  - SHOW_ON: led_valid=1, led_val=seq[idx] for exactly SHOW_CYCLES cycles -> SHOW_GAP.
//  - SHOW_GAP: dark for GAP_CYCLES cycles.
//    Then if idx==len-1: idx<=0 -> INPUT; else idx<=idx+1 -> SHOW_ON.
//  - Latency: start sampled at edge k -> APPEND in cycle k+1 -> first led_valid in cycle k+2.
//  - INPUT, on btn_valid:
//    - btn_val!=seq[idx] -> LOSE.
//    - Match and idx<len-1 -> idx+1, stay in INPUT.
//    - Match and idx==len-1 -> WIN if len==MAX_LEN, else APPEND.
//  - btn_valid outside INPUT is ignored; presses are not queued.
//  - start while busy is ignored.
//  - LOSE/WIN: hold flag and level. start -> APPEND with len reset to 0 (flag drops same edge).
//  - Simultaneous start+btn_valid: start wins in WIN/LOSE/IDLE; btn wins in INPUT.
//  - Counters saturate-free: timer reloads on each state entry; idx never exceeds len-1.
//  - reset mid-operation: immediate return to IDLE, outputs 0.
// CONFIGURATION
//  - SIMON_TIMEOUT_EN defined:
//    - An INPUT-state timer counts cycles since the last press or INPUT entry.
//    - Reaching TIMEOUT_CYCLES with no btn_valid -> LOSE.
//    - A press on the expiry cycle is evaluated normally and takes precedence.
//  - Undefined: no timer logic; INPUT waits indefinitely.
// STRUCTURE
//  - Package simon_pkg: typedef logic[1:0] sym_t; typedef enum state_t
//    {IDLE,APPEND,SHOW_ON,SHOW_GAP,INPUT,LOSE,WIN}; sym_t localparams for the 4 colours.
//  - Sub-module phase_timer: loadable down-counter, done pulse at 0.
//    Shared by SHOW_ON, SHOW_GAP and INPUT timeout.
//  - Sequence storage: MAX_LEN x sym_t register array inside this module.
// TESTING (bench: MAX_LEN=4, SHOW_CYCLES=4, GAP_CYCLES=2, TIMEOUT_CYCLES=8)
//  1. Reset, start, rand_in=2 -> led_valid high 4 cycles with led_val=2, then 2 dark,
//     then INPUT, level=1, busy=1.
//  2. Continue: btn 2 with rand_in=1 -> APPEND; level=2; shows 2 then 1; INPUT.
//  3. In INPUT at idx=0, btn 3 (expected 2) -> game_over=1, busy=0, level=2 held.
//     start -> game_over=0, level=1.
//  4. Four correct rounds -> win=1, level=4. btn_valid during SHOW_ON has no effect on idx/state.
//  5. Assert reset during SHOW_ON -> same cycle led_valid=0, level=0, busy=0. start works after release.
//  6. SIMON_TIMEOUT_EN: no press for 8 cycles in INPUT -> game_over=1.
//     Undefined: still INPUT after 100 cycles.

Source files
------------

// File: rtl/simon_pkg.sv
// Shared types and constants for the 4-symbol memory game sequencer.
package simon_pkg;

    typedef logic [1:0] sym_t;

    typedef enum logic [2:0] {
        IDLE,
        APPEND,
        SHOW_ON,
        SHOW_GAP,
        INPUT,
        LOSE,
        WIN
    } state_t;

    localparam sym_t SYM_RED    = 2'd0;
    localparam sym_t SYM_GREEN  = 2'd1;
    localparam sym_t SYM_BLUE   = 2'd2;
    localparam sym_t SYM_YELLOW = 2'd3;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/simon_seq_ctrl_phase_timer.sv
// Loadable down-counter; done is high whenever the count has reached zero.
module phase_timer #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         done
);

    logic [W-1:0] count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (count != '0) begin
            count <= count - W'(1);
        end
    end

    assign done = (count == '0);

endmodule

// File: rtl/simon_seq_ctrl.sv
// Memory-game sequencer: grows, plays and checks the symbol sequence.
// Optional INPUT-state inactivity loss is enabled by defining SIMON_TIMEOUT_EN.
module simon_seq_ctrl #(
    parameter int MAX_LEN        = 16,
    parameter int SHOW_CYCLES    = 4,
    parameter int GAP_CYCLES     = 2,
    parameter int TIMEOUT_CYCLES = 8,
    parameter int LEN_W          = $clog2(MAX_LEN + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       rand_in,
    input  logic             btn_valid,
    input  logic [1:0]       btn_val,
    output logic             led_valid,
    output logic [1:0]       led_val,
    output logic [LEN_W-1:0] level,
    output logic             busy,
    output logic             game_over,
    output logic             win
);

    import simon_pkg::*;

    localparam int IDX_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam int TMAX  = max3(SHOW_CYCLES, GAP_CYCLES, TIMEOUT_CYCLES);
    localparam int TW    = $clog2(TMAX + 1);

    state_t           state, state_n;
    logic [LEN_W-1:0] len, len_n;
    logic [IDX_W-1:0] idx, idx_n;
    sym_t             seq [MAX_LEN];
    sym_t             cur_sym;
    logic             last_idx;
    logic             tmr_load;
    logic [TW-1:0]    tmr_val;
    logic             tmr_done;

    phase_timer #(.W(TW)) u_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (tmr_load),
        .load_val (tmr_val),
        .done     (tmr_done)
    );

    assign cur_sym  = seq[idx];
    assign last_idx = (LEN_W'(idx) == len - LEN_W'(1));

    // Storage is never reset; only positions below len are ever read.
    always_ff @(posedge clk) begin
        if (state == APPEND) begin
            seq[len[IDX_W-1:0]] <= rand_in;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            len   <= '0;
            idx   <= '0;
        end else begin
            state <= state_n;
            len   <= len_n;
            idx   <= idx_n;
        end
    end

    always_comb begin
        state_n  = state;
        len_n    = len;
        idx_n    = idx;
        tmr_load = 1'b0;
        tmr_val  = '0;
        unique case (state)
            IDLE, LOSE, WIN: begin
                if (start) begin
                    state_n = APPEND;
                    len_n   = '0;
                end
            end
            APPEND: begin
                len_n    = len + LEN_W'(1);
                idx_n    = '0;
                state_n  = SHOW_ON;
                tmr_load = 1'b1;
                tmr_val  = TW'(SHOW_CYCLES - 1);
            end
            SHOW_ON: begin
                if (tmr_done) begin
                    state_n  = SHOW_GAP;
                    tmr_load = 1'b1;
                    tmr_val  = TW'(GAP_CYCLES - 1);
                end
            end
            SHOW_GAP: begin
                if (tmr_done) begin
                    tmr_load = 1'b1;
                    if (last_idx) begin
                        idx_n   = '0;
                        state_n = INPUT;
                        tmr_val = TW'(TIMEOUT_CYCLES - 1);
                    end else begin
                        idx_n   = idx + IDX_W'(1);
                        state_n = SHOW_ON;
                        tmr_val = TW'(SHOW_CYCLES - 1);
                    end
                end
            end
            INPUT: begin
                // A press always takes precedence over an expiring timeout.
                if (btn_valid) begin
                    if (btn_val != cur_sym) begin
                        state_n = LOSE;
                    end else if (!last_idx) begin
                        idx_n    = idx + IDX_W'(1);
                        tmr_load = 1'b1;
                        tmr_val  = TW'(TIMEOUT_CYCLES - 1);
                    end else if (len == LEN_W'(MAX_LEN)) begin
                        state_n = WIN;
                    end else begin
                        state_n = APPEND;
                    end
                end
`ifdef SIMON_TIMEOUT_EN
                else if (tmr_done) begin
                    state_n = LOSE;
                end
`else
                else begin
                    state_n = INPUT;
                end
`endif
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    assign led_valid = (state == SHOW_ON);
    assign led_val   = led_valid ? cur_sym : 2'd0;
    assign level     = len;
    assign busy      = (state inside {APPEND, SHOW_ON, SHOW_GAP, INPUT});
    assign game_over = (state == LOSE);
    assign win       = (state == WIN);

endmodule

// File: tb/tb_simon_seq_ctrl.sv
// Directed self-checking bench for simon_seq_ctrl (MAX_LEN=4, show 4, gap 2, timeout 8).
module tb_simon_seq_ctrl;

    logic       clk;
    logic       reset;
    logic       start;
    logic [1:0] rand_in;
    logic       btn_valid;
    logic [1:0] btn_val;
    logic       led_valid;
    logic [1:0] led_val;
    logic [2:0] level;
    logic       busy;
    logic       game_over;
    logic       win;

    int checks = 0;
    int passed = 0;

    logic [1:0] model_seq [4];
    int         model_len;

    simon_seq_ctrl #(
        .MAX_LEN        (4),
        .SHOW_CYCLES    (4),
        .GAP_CYCLES     (2),
        .TIMEOUT_CYCLES (8)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .rand_in   (rand_in),
        .btn_valid (btn_valid),
        .btn_val   (btn_val),
        .led_valid (led_valid),
        .led_val   (led_val),
        .level     (level),
        .busy      (busy),
        .game_over (game_over),
        .win       (win)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            $display("[TB] FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end else begin
            passed++;
        end
    endtask

    // Drive inputs for one sampling edge, then drop the pulses; returns at the following negedge.
    task automatic applyStimulus(input logic s, input logic bv, input logic [1:0] b, input logic [1:0] r);
        start     = s;
        btn_valid = bv;
        btn_val   = b;
        rand_in   = r;
        @(negedge clk);
        start     = 1'b0;
        btn_valid = 1'b0;
    endtask

    // Called at the first SHOW_ON cycle; returns at the first INPUT cycle.
    task automatic checkShow(input int n, input bit poke);
        for (int j = 0; j < n; j++) begin
            for (int c = 0; c < 4; c++) begin
                checkOutput("show_valid", led_valid, 1);
                checkOutput("show_val", led_val, model_seq[j]);
                if (poke && j == 0 && c == 1) begin
                    btn_valid = 1'b1;
                    btn_val   = model_seq[0] + 2'd1;
                    start     = 1'b1;
                end
                @(negedge clk);
                btn_valid = 1'b0;
                start     = 1'b0;
            end
            for (int c = 0; c < 2; c++) begin
                checkOutput("gap_valid", led_valid, 0);
                checkOutput("gap_val", led_val, 0);
                checkOutput("gap_busy", busy, 1);
                @(negedge clk);
            end
        end
        checkOutput("input_busy", busy, 1);
        checkOutput("input_dark", led_valid, 0);
        checkOutput("input_level", level, model_len);
    endtask

    // Replays the whole stored sequence correctly; next_rand feeds the following APPEND.
    task automatic pressRound(input logic [1:0] next_rand, input bit poke);
        int n;
        n = model_len;
        for (int j = 0; j < n; j++) begin
            applyStimulus(1'b0, 1'b1, model_seq[j], next_rand);
            if (j < n - 1) begin
                checkOutput("press_stay_busy", busy, 1);
                checkOutput("press_stay_win", win, 0);
            end
        end
        if (n == 4) begin
            checkOutput("win_flag", win, 1);
            checkOutput("win_busy", busy, 0);
            checkOutput("win_level", level, 4);
        end else begin
            model_seq[n] = next_rand;
            model_len    = n + 1;
            checkOutput("append_busy", busy, 1);
            checkOutput("append_dark", led_valid, 0);
            @(negedge clk);
            checkOutput("round_level", level, model_len);
            checkShow(model_len, poke);
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        reset     = 1'b1;
        start     = 1'b0;
        rand_in   = 2'd0;
        btn_valid = 1'b0;
        btn_val   = 2'd0;
        model_len = 0;
        repeat (2) @(negedge clk);
        checkOutput("rst_led_valid", led_valid, 0);
        checkOutput("rst_led_val", led_val, 0);
        checkOutput("rst_level", level, 0);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_game_over", game_over, 0);
        checkOutput("rst_win", win, 0);
        reset = 1'b0;
        @(negedge clk);
        applyStimulus(1'b0, 1'b1, 2'd1, 2'd0);
        checkOutput("idle_btn_ignored", busy, 0);

        // Test 1: first round shows symbol 2
        applyStimulus(1'b1, 1'b0, 2'd0, 2'd2);
        checkOutput("t1_append_busy", busy, 1);
        checkOutput("t1_append_dark", led_valid, 0);
        model_seq[0] = 2'd2;
        model_len    = 1;
        @(negedge clk);
        checkOutput("t1_level", level, 1);
        checkShow(1, 1'b0);

        // Test 2: correct press, sequence grows to {2,1}
        pressRound(2'd1, 1'b0);

        // Test 3: wrong press at idx 0
        applyStimulus(1'b0, 1'b1, 2'd3, 2'd0);
        checkOutput("t3_game_over", game_over, 1);
        checkOutput("t3_busy", busy, 0);
        checkOutput("t3_level", level, 2);
        applyStimulus(1'b0, 1'b1, 2'd2, 2'd0);
        checkOutput("t3_lose_btn_ignored", game_over, 1);
        checkOutput("t3_lose_level_held", level, 2);
        applyStimulus(1'b1, 1'b0, 2'd0, 2'd3);
        checkOutput("t3_restart_flag_drop", game_over, 0);
        checkOutput("t3_restart_busy", busy, 1);
        model_seq[0] = 2'd3;
        model_len    = 1;
        @(negedge clk);
        checkOutput("t3_restart_level", level, 1);
        checkShow(1, 1'b0);

        // Test 4: rounds up to MAX_LEN, with presses/starts poked during SHOW_ON
        pressRound(2'd0, 1'b1);
        pressRound(2'd1, 1'b0);
        pressRound(2'd2, 1'b1);
        pressRound(2'd0, 1'b0);
        applyStimulus(1'b0, 1'b1, 2'd3, 2'd0);
        checkOutput("t4_win_hold", win, 1);
        checkOutput("t4_win_level_hold", level, 4);
        applyStimulus(1'b1, 1'b1, 2'd3, 2'd1);
        checkOutput("t4_start_beats_btn_win", win, 0);
        checkOutput("t4_start_beats_btn_busy", busy, 1);
        model_seq[0] = 2'd1;
        model_len    = 1;
        @(negedge clk);
        checkOutput("t5_pre_led_valid", led_valid, 1);

        // Test 5: asynchronous reset in SHOW_ON
        reset = 1'b1;
        #1;
        checkOutput("t5_rst_led_valid", led_valid, 0);
        checkOutput("t5_rst_level", level, 0);
        checkOutput("t5_rst_busy", busy, 0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        checkOutput("t5_idle_after_release", busy, 0);
        applyStimulus(1'b1, 1'b0, 2'd0, 2'd0);
        checkOutput("t5_restart_busy", busy, 1);
        model_seq[0] = 2'd0;
        model_len    = 1;
        @(negedge clk);
        checkShow(1, 1'b0);

        // Test 6: INPUT inactivity
`ifdef SIMON_TIMEOUT_EN
        repeat (7) @(negedge clk);
        checkOutput("t6_before_timeout_busy", busy, 1);
        checkOutput("t6_before_timeout_lose", game_over, 0);
        @(negedge clk);
        checkOutput("t6_timeout_lose", game_over, 1);
        checkOutput("t6_timeout_busy", busy, 0);
`else
        repeat (100) @(negedge clk);
        checkOutput("t6_wait_busy", busy, 1);
        checkOutput("t6_wait_no_lose", game_over, 0);
        checkOutput("t6_wait_dark", led_valid, 0);
        applyStimulus(1'b0, 1'b1, 2'd0, 2'd2);
        checkOutput("t6_late_press_append", busy, 1);
        checkOutput("t6_late_press_no_lose", game_over, 0);
`endif

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
